// File: rtl/vga_timing_pkg.sv
// Shared raster definitions: 1280x1024@60 default geometry, 12-bit coordinate type
// and the derived line/frame totals used by the timing generator and its consumers.
package vga_timing_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_t;

    localparam int   H_ACTIVE_DEF = 1280;
    localparam int   H_FP_DEF     = 48;
    localparam int   H_SYNC_DEF   = 112;
    localparam int   H_BP_DEF     = 248;
    localparam int   V_ACTIVE_DEF = 1024;
    localparam int   V_FP_DEF     = 1;
    localparam int   V_SYNC_DEF   = 3;
    localparam int   V_BP_DEF     = 38;
    localparam logic HS_POL_DEF   = 1'b1;
    localparam logic VS_POL_DEF   = 1'b1;
    localparam int   SYNC_DLY_DEF = 2;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// CE-gated shift register that re-times the sync/active flags so they line up with
// pixel colour produced DEPTH pixel steps after the coordinates.
module vga_sync_delay #(
    parameter int           W       = 3,
    parameter int           DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH < 1) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] stage_r [DEPTH];

            // Shift one stage per pixel step; idle value on reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RST_VAL;
                    end
                end else if (ce) begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, HS/VS, active video and line/frame pulses.
// Define VGA_SYNC_DELAY_EN to delay HS/VS/ACTIVE by SYNC_DLY pixel steps.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic HS_POL   = HS_POL_DEF,
    parameter logic VS_POL   = VS_POL_DEF,
    parameter int   SYNC_DLY = SYNC_DLY_DEF
) (
    input  logic               CLK_VGA,
    input  logic               RESET_N,
    input  logic               PIX_CE,
    output logic [COORD_W-1:0] VGA_horzCoord,
    output logic [COORD_W-1:0] VGA_vertCoord,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_ACTIVE,
    output logic               LINE_START,
    output logic               FRAME_START
);

    localparam int     H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam int     HS_BEGIN = H_ACTIVE + H_FP;
    localparam int     HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int     VS_BEGIN = V_ACTIVE + V_FP;
    localparam int     VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam sync_t  SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, active: 1'b0};

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || SYNC_DLY < 0) begin : g_bad_cfg
            $error("vga_timing_gen: raster totals exceed 12-bit coordinates or negative delay");
        end
    endgenerate

    coord_t col_r;
    coord_t row_r;
    sync_t  sync_r;
    logic   line_start_r;
    logic   frame_start_r;

    coord_t col_nxt_s;
    coord_t row_nxt_s;
    sync_t  sync_nxt_s;
    logic   line_nxt_s;
    logic   frame_nxt_s;
    sync_t  sync_out_s;

    // Raster advance; flags are decoded from the next position so they register with it
    always_comb begin
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        line_nxt_s  = 1'b0;
        frame_nxt_s = 1'b0;
        if (PIX_CE) begin
            if (col_r == H_LAST) begin
                col_nxt_s  = 12'd0;
                line_nxt_s = 1'b1;
                if (row_r == V_LAST) begin
                    row_nxt_s   = 12'd0;
                    frame_nxt_s = 1'b1;
                end else begin
                    row_nxt_s = row_r + 12'd1;
                end
            end else begin
                col_nxt_s = col_r + 12'd1;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end

        sync_nxt_s.hs     = ((int'(col_nxt_s) >= HS_BEGIN) && (int'(col_nxt_s) < HS_END)) ? HS_POL : ~HS_POL;
        sync_nxt_s.vs     = ((int'(row_nxt_s) >= VS_BEGIN) && (int'(row_nxt_s) < VS_END)) ? VS_POL : ~VS_POL;
        sync_nxt_s.active = (int'(col_nxt_s) < H_ACTIVE) && (int'(row_nxt_s) < V_ACTIVE);
    end

    // Position and flag registers; reset parks on the last blanking pixel
    always_ff @(posedge CLK_VGA or negedge RESET_N) begin
        if (!RESET_N) begin
            col_r         <= H_LAST;
            row_r         <= V_LAST;
            sync_r        <= SYNC_IDLE;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            col_r         <= col_nxt_s;
            row_r         <= row_nxt_s;
            sync_r        <= sync_nxt_s;
            line_start_r  <= line_nxt_s;
            frame_start_r <= frame_nxt_s;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    vga_sync_delay #(
        .W       ($bits(sync_t)),
        .DEPTH   (SYNC_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (CLK_VGA),
        .rst_n (RESET_N),
        .ce    (PIX_CE),
        .d     (sync_r),
        .q     (sync_out_s)
    );
`else
    assign sync_out_s = sync_r;
`endif

    assign VGA_horzCoord = col_r;
    assign VGA_vertCoord = row_r;
    assign VGA_HS        = sync_out_s.hs;
    assign VGA_VS        = sync_out_s.vs;
    assign VGA_ACTIVE    = sync_out_s.active;
    assign LINE_START    = line_start_r;
    assign FRAME_START   = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a reduced-geometry instance (inverted sync polarity) covers frame
// wrap and VS, while a default 1280x1024 instance covers reset values and row-0 timing.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    typedef struct packed {
        logic [11:0] col;
        logic [11:0] row;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct packed {
        obs_t s;
        obs_t d;
    } pair_t;

    typedef struct {
        int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp;
        bit hpol; bit vpol;
    } geo_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_ce;

    logic [11:0] small_col_s, small_row_s, dflt_col_s, dflt_row_s;
    logic        small_hs_s, small_vs_s, small_act_s, small_ls_s, small_fs_s;
    logic        dflt_hs_s, dflt_vs_s, dflt_act_s, dflt_ls_s, dflt_fs_s;
    obs_t        small_obs_s, dflt_obs_s;

    int          n_vec = 0;
    int          n_err = 0;
    geo_t        geo [2];
    int          mcol [2];
    int          mrow [2];
    logic [2:0]  hist [2][3];
    pair_t       sbq [$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (12), .V_FP (1), .V_SYNC (3), .V_BP (2),
        .HS_POL (1'b0), .VS_POL (1'b0), .SYNC_DLY (2)
    ) dut_small (
        .CLK_VGA       (clk),
        .RESET_N       (rst_n),
        .PIX_CE        (pix_ce),
        .VGA_horzCoord (small_col_s),
        .VGA_vertCoord (small_row_s),
        .VGA_HS        (small_hs_s),
        .VGA_VS        (small_vs_s),
        .VGA_ACTIVE    (small_act_s),
        .LINE_START    (small_ls_s),
        .FRAME_START   (small_fs_s)
    );

    vga_timing_gen dut_dflt (
        .CLK_VGA       (clk),
        .RESET_N       (rst_n),
        .PIX_CE        (pix_ce),
        .VGA_horzCoord (dflt_col_s),
        .VGA_vertCoord (dflt_row_s),
        .VGA_HS        (dflt_hs_s),
        .VGA_VS        (dflt_vs_s),
        .VGA_ACTIVE    (dflt_act_s),
        .LINE_START    (dflt_ls_s),
        .FRAME_START   (dflt_fs_s)
    );

    assign small_obs_s = {small_col_s, small_row_s, small_hs_s, small_vs_s, small_act_s, small_ls_s, small_fs_s};
    assign dflt_obs_s  = {dflt_col_s, dflt_row_s, dflt_hs_s, dflt_vs_s, dflt_act_s, dflt_ls_s, dflt_fs_s};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] sync_of(input geo_t g, input int c, input int r);
        logic hs_v, vs_v, act_v;
        hs_v  = (c >= g.ha + g.hfp) && (c < g.ha + g.hfp + g.hsw);
        vs_v  = (r >= g.va + g.vfp) && (r < g.va + g.vfp + g.vsw);
        act_v = (c < g.ha) && (r < g.va);
        return {hs_v ? g.hpol : ~g.hpol, vs_v ? g.vpol : ~g.vpol, act_v};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcol[d] = geo[d].ha + geo[d].hfp + geo[d].hsw + geo[d].hbp - 1;
            mrow[d] = geo[d].va + geo[d].vfp + geo[d].vsw + geo[d].vbp - 1;
            for (int i = 0; i < 3; i++) hist[d][i] = sync_of(geo[d], mcol[d], mrow[d]);
        end
        sbq.delete();
    endtask

    task automatic adv(input int d, input bit ce, output obs_t o);
        int ht, vt;
        ht = geo[d].ha + geo[d].hfp + geo[d].hsw + geo[d].hbp;
        vt = geo[d].va + geo[d].vfp + geo[d].vsw + geo[d].vbp;
        if (ce) begin
            if (mcol[d] == ht - 1) begin
                mcol[d] = 0;
                mrow[d] = (mrow[d] == vt - 1) ? 0 : mrow[d] + 1;
            end else begin
                mcol[d] = mcol[d] + 1;
            end
            for (int i = 2; i > 0; i--) hist[d][i] = hist[d][i-1];
            hist[d][0] = sync_of(geo[d], mcol[d], mrow[d]);
        end
        o.col = 12'(mcol[d]);
        o.row = 12'(mrow[d]);
        {o.hs, o.vs, o.act} = hist[d][DLY];
        o.ls = ce && (mcol[d] == 0);
        o.fs = ce && (mcol[d] == 0) && (mrow[d] == 0);
    endtask

    // Drive one pixel-clock cycle and queue the outputs expected after its edge
    task automatic step(input bit ce);
        pair_t p;
        @(negedge clk);
        pix_ce = ce;
        adv(0, ce, p.s);
        adv(1, ce, p.d);
        sbq.push_back(p);
    endtask

    task automatic cmp_obs(input string pfx, input obs_t o, input obs_t e);
        check({pfx, "_col"}, 32'(o.col), 32'(e.col));
        check({pfx, "_row"}, 32'(o.row), 32'(e.row));
        check({pfx, "_hs"},  32'(o.hs),  32'(e.hs));
        check({pfx, "_vs"},  32'(o.vs),  32'(e.vs));
        check({pfx, "_act"}, 32'(o.act), 32'(e.act));
        check({pfx, "_ls"},  32'(o.ls),  32'(e.ls));
        check({pfx, "_fs"},  32'(o.fs),  32'(e.fs));
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_d_col"}, 32'(dflt_col_s), 32'd1687);
        check({pfx, "_d_row"}, 32'(dflt_row_s), 32'd1065);
        check({pfx, "_d_hs"},  32'(dflt_hs_s),  32'd0);
        check({pfx, "_d_vs"},  32'(dflt_vs_s),  32'd0);
        check({pfx, "_d_act"}, 32'(dflt_act_s), 32'd0);
        check({pfx, "_d_ls"},  32'(dflt_ls_s),  32'd0);
        check({pfx, "_d_fs"},  32'(dflt_fs_s),  32'd0);
        check({pfx, "_s_col"}, 32'(small_col_s), 32'd31);
        check({pfx, "_s_row"}, 32'(small_row_s), 32'd17);
        check({pfx, "_s_hs"},  32'(small_hs_s),  32'd1);
        check({pfx, "_s_vs"},  32'(small_vs_s),  32'd1);
        check({pfx, "_s_act"}, 32'(small_act_s), 32'd0);
    endtask

    // Scoreboard drain, one sample after each active edge
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                p = sbq.pop_front();
                cmp_obs("small", small_obs_s, p.s);
                cmp_obs("dflt", dflt_obs_s, p.d);
            end
        end
    end

    initial begin
        bit started, done, ce;
        int n_ce;
        geo[0] = '{16, 4, 6, 6, 12, 1, 3, 2, 1'b0, 1'b0};
        geo[1] = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1};
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        step(1'b1);
        #7;
        check("first_col", 32'(dflt_col_s), 32'd0);
        check("first_row", 32'(dflt_row_s), 32'd0);
        check("first_fs",  32'(dflt_fs_s),  32'd1);
        check("first_ls",  32'(dflt_ls_s),  32'd1);
        check("first_act", 32'(dflt_act_s), (DLY == 0) ? 32'd1 : 32'd0);
        step(1'b1);
        #7;
        check("fs_one_cycle", 32'(dflt_fs_s), 32'd0);

        repeat (1700) step(1'b1);

        for (int i = 0; i < 40; i++) step(i % 4 == 0);
        repeat (10) step(1'b0);

        started = 1'b0;
        done    = 1'b0;
        n_ce    = 0;
        for (int i = 0; i < 8000 && !done; i++) begin
            ce = (i % 4 == 0);
            step(ce);
            #7;
            if (ce && started) n_ce++;
            if (small_fs_s) begin
                if (started) done = 1'b1;
                else started = 1'b1;
            end
        end
        check("frame_len", 32'(n_ce), 32'd576);
        check("frame_len_done", 32'(done), 32'd1);

        repeat (37) step(1'b1);
        @(negedge clk);
        pix_ce = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1);
        #7;
        check("restart_col", 32'(small_col_s), 32'd0);
        check("restart_row", 32'(small_row_s), 32'd0);
        check("restart_fs",  32'(small_fs_s),  32'd1);
        repeat (40) step(1'b1);
        @(negedge clk);
        pix_ce = 1'b0;
        #10;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
